// File: rtl/fft_frame_sequencer_if.sv
// Serial sample/bin stream bundle for fft_frame_sequencer.
// The sequencer sits on the slave side; the source/sink environment sits on the master side.
interface fft_frame_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [2:0]        out_index;
    logic              out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frames a serial complex stream into 8-sample blocks for a free-running 8-point FFT core,
// waits out the core latency, then streams the 8 captured bins back out serially.
module fft_frame_sequencer #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CORE_LATENCY = 48,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fft_frame_sequencer_if.slave  io_stream,
    output logic [8*DATA_W-1:0]   o_core_xin,
    output logic [8*DATA_W-1:0]   o_core_yin,
    input  logic [8*DATA_W-1:0]   i_core_xout,
    input  logic [8*DATA_W-1:0]   i_core_yout,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_frame_count
);
    localparam int unsigned LAT_W = $clog2(CORE_LATENCY + 1);

    typedef enum logic [1:0] {InFill, InCompute, InHold} in_state_e;
    typedef enum logic       {OutIdle, OutDrain}         out_state_e;

    in_state_e          r_in_state;
    logic [2:0]         r_wr_idx;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic               r_in_ready;
    logic [DATA_W-1:0]  r_slot_re [8];
    logic [DATA_W-1:0]  r_slot_im [8];
    logic [8*DATA_W-1:0] r_core_xin;
    logic [8*DATA_W-1:0] r_core_yin;

    out_state_e         r_out_state;
    logic [2:0]         r_rd_idx;
    logic [DATA_W-1:0]  r_buf_re [8];
    logic [DATA_W-1:0]  r_buf_im [8];
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_re;
    logic [DATA_W-1:0]  r_out_im;
    logic [2:0]         r_out_index;
    logic               r_out_last;
    logic [CNT_W-1:0]   r_frame_count;

    logic               w_accept;
    logic               w_out_hs;
    logic               w_bin7_hs;
    logic               w_out_free;
    logic               w_capture;
    logic [2:0]         w_rd_next;

    assign w_accept   = r_in_ready && io_stream.in_valid;
    assign w_out_hs   = r_out_valid && io_stream.out_ready;
    assign w_bin7_hs  = (r_out_state == OutDrain) && w_out_hs && (r_rd_idx == 3'd7);
    // Output buffer may be overwritten when idle or on the very edge its last bin leaves.
    assign w_out_free = (r_out_state == OutIdle) || w_bin7_hs;
    assign w_capture  = w_out_free &&
                        (((r_in_state == InCompute) && (r_lat_cnt == LAT_W'(1))) ||
                         (r_in_state == InHold));
    assign w_rd_next  = r_rd_idx + 3'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_state <= InFill;
            r_wr_idx   <= 3'd0;
            r_lat_cnt  <= '0;
            r_in_ready <= 1'b1;
            r_core_xin <= '0;
            r_core_yin <= '0;
            for (int k = 0; k < 8; k++) begin
                r_slot_re[k] <= '0;
                r_slot_im[k] <= '0;
            end
        end else begin
            unique case (r_in_state)
                InFill: begin
                    if (w_accept) begin
                        r_slot_re[r_wr_idx] <= io_stream.in_re;
                        r_slot_im[r_wr_idx] <= io_stream.in_im;
                        r_wr_idx            <= r_wr_idx + 3'd1;
                        if (r_wr_idx == 3'd7) begin
                            for (int k = 0; k < 7; k++) begin
                                r_core_xin[k*DATA_W +: DATA_W] <= r_slot_re[k];
                                r_core_yin[k*DATA_W +: DATA_W] <= r_slot_im[k];
                            end
                            r_core_xin[7*DATA_W +: DATA_W] <= io_stream.in_re;
                            r_core_yin[7*DATA_W +: DATA_W] <= io_stream.in_im;
                            r_lat_cnt  <= LAT_W'(CORE_LATENCY);
                            r_in_state <= InCompute;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                InCompute: begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    if (r_lat_cnt == LAT_W'(1)) begin
                        if (w_capture) begin
                            r_in_state <= InFill;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_in_state <= InHold;
                        end
                    end
                end
                InHold: begin
                    if (w_capture) begin
                        r_in_state <= InFill;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_in_state <= InFill;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_state   <= OutIdle;
            r_rd_idx      <= 3'd0;
            r_out_valid   <= 1'b0;
            r_out_re      <= '0;
            r_out_im      <= '0;
            r_out_index   <= 3'd0;
            r_out_last    <= 1'b0;
            r_frame_count <= '0;
            for (int k = 0; k < 8; k++) begin
                r_buf_re[k] <= '0;
                r_buf_im[k] <= '0;
            end
        end else begin
            if (w_bin7_hs) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
            end
            if (w_capture) begin
                for (int k = 0; k < 8; k++) begin
                    r_buf_re[k] <= i_core_xout[k*DATA_W +: DATA_W];
                    r_buf_im[k] <= i_core_yout[k*DATA_W +: DATA_W];
                end
                r_out_state <= OutDrain;
                r_rd_idx    <= 3'd0;
                r_out_valid <= 1'b1;
                r_out_re    <= i_core_xout[DATA_W-1:0];
                r_out_im    <= i_core_yout[DATA_W-1:0];
                r_out_index <= 3'd0;
                r_out_last  <= 1'b0;
            end else if ((r_out_state == OutDrain) && w_out_hs) begin
                if (r_rd_idx == 3'd7) begin
                    r_out_state <= OutIdle;
                    r_rd_idx    <= 3'd0;
                    r_out_valid <= 1'b0;
                    r_out_re    <= '0;
                    r_out_im    <= '0;
                    r_out_index <= 3'd0;
                    r_out_last  <= 1'b0;
                end else begin
                    r_rd_idx    <= w_rd_next;
                    r_out_re    <= r_buf_re[w_rd_next];
                    r_out_im    <= r_buf_im[w_rd_next];
                    r_out_index <= w_rd_next;
                    r_out_last  <= (w_rd_next == 3'd7);
                end
            end
        end
    end

    assign io_stream.in_ready  = r_in_ready;
    assign io_stream.out_valid = r_out_valid;
    assign io_stream.out_re    = r_out_re;
    assign io_stream.out_im    = r_out_im;
    assign io_stream.out_index = r_out_index;
    assign io_stream.out_last  = r_out_last;
    assign o_core_xin          = r_core_xin;
    assign o_core_yin          = r_core_yin;
    assign o_frame_count       = r_frame_count;
    assign o_busy              = (r_in_state != InFill) || (r_out_state == OutDrain);
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a delay-line stand-in for the FFT core,
// so every bin must come back equal to the sample written in the same slot.
module tb_fft_frame_sequencer;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 48;
    localparam int unsigned CW  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.DATA_W(DW)) stream ();
    logic [8*DW-1:0] xin, yin, xout, yout;
    logic            busy;
    logic [CW-1:0]   fcnt;

    fft_frame_sequencer #(
        .DATA_W       (DW),
        .CORE_LATENCY (LAT),
        .CNT_W        (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .io_stream     (stream.slave),
        .o_core_xin    (xin),
        .o_core_yin    (yin),
        .i_core_xout   (xout),
        .i_core_yout   (yout),
        .o_busy        (busy),
        .o_frame_count (fcnt)
    );

    // Core stand-in: output settles LAT-1 edges after an input change, ready for the capture edge.
    logic [8*DW-1:0] px [LAT-1];
    logic [8*DW-1:0] py [LAT-1];
    always_ff @(posedge clk) begin
        px[0] <= xin;
        py[0] <= yin;
        for (int i = 1; i < LAT - 1; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign xout = px[LAT-2];
    assign yout = py[LAT-2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int last_acc;
    logic [DW-1:0] fr_re [2][8];
    logic [DW-1:0] fr_im [2][8];

    typedef struct {
        logic [DW-1:0] in_re;
        logic [DW-1:0] in_im;
        logic [DW-1:0] exp_re;
        logic [DW-1:0] exp_im;
        logic          exp_last;
    } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stream.in_valid  = 1'b0;
        stream.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one sample until accepted; optional idle cycles carry junk data first.
    task automatic push_sample(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit gaps);
        bit acc;
        bit done = 1'b0;
        if (gaps) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                stream.in_valid = 1'b0;
                stream.in_re    = DW'($urandom);
                stream.in_im    = DW'($urandom);
                tick();
            end
        end
        stream.in_valid = 1'b1;
        stream.in_re    = re;
        stream.in_im    = im;
        for (int i = 0; i < 1000 && !done; i++) begin
            acc = stream.in_ready;
            tick();
            if (acc) done = 1'b1;
        end
        if (!done) fail_timeout("push_sample");
        last_acc = cyc;
    endtask

    task automatic push_frame(input int f, input bit gaps);
        for (int k = 0; k < 8; k++) push_sample(fr_re[f][k], fr_im[f][k], gaps);
        stream.in_valid = 1'b0;
    endtask

    // Assumes out_ready=1; returns after the handshake edge.
    task automatic get_bin(output logic [DW-1:0] re, output logic [DW-1:0] im,
                           output logic [2:0] idx, output logic last, output int waited);
        bit got = 1'b0;
        re = '0; im = '0; idx = '0; last = 1'b0; waited = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            if (stream.out_valid) begin
                re   = stream.out_re;
                im   = stream.out_im;
                idx  = stream.out_index;
                last = stream.out_last;
                got  = 1'b1;
            end else begin
                waited++;
            end
            tick();
        end
        if (!got) fail_timeout("get_bin");
    endtask

    task automatic recv_frame(input int f, input string tag, output int waits);
        logic [DW-1:0] re, im;
        logic [2:0]    idx;
        logic          last;
        int            w;
        waits = 0;
        for (int k = 0; k < 8; k++) begin
            get_bin(re, im, idx, last, w);
            waits += w;
            check({tag, "_re"}, 64'(re), 64'(fr_re[f][k]));
            check({tag, "_im"}, 64'(im), 64'(fr_im[f][k]));
            check({tag, "_idx"}, 64'(idx), 64'(k));
            check({tag, "_last"}, 64'(last), 64'(k == 7));
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (!busy && !stream.out_valid) done = 1'b1;
            else tick();
        end
        if (!done) fail_timeout(name);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(stream.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(stream.out_valid), 64'd0);
        check({tag, "_out_re"}, 64'({stream.out_re, stream.out_im}), 64'd0);
        check({tag, "_out_idx_last"}, 64'({stream.out_index, stream.out_last}), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_fcnt"}, 64'(fcnt), 64'd0);
        check({tag, "_core_in"}, 64'((xin != '0) || (yin != '0)), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] re, im;
        logic [2:0]    idx;
        logic          last;
        int            w, waits, t0;
        bit            stable;

        for (int k = 0; k < 8; k++) begin
            tbl[k].in_re    = DW'(k + 1);
            tbl[k].in_im    = DW'(-(k + 1));
            tbl[k].exp_re   = DW'(k + 1);
            tbl[k].exp_im   = DW'(-(k + 1));
            tbl[k].exp_last = (k == 7);
        end
        stream.in_valid  = 1'b0;
        stream.in_re     = '0;
        stream.in_im     = '0;
        stream.out_ready = 1'b0;

        // Reset values, then a single frame with latency measured from the last accept.
        do_reset();
        check_reset_state("rst");
        stream.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) push_sample(tbl[k].in_re, tbl[k].in_im, 1'b0);
        stream.in_valid = 1'b0;
        t0 = last_acc;
        for (int i = 0; i < 200 && !stream.out_valid; i++) tick();
        check("t1_latency", 64'(cyc - t0), 64'(LAT));
        for (int k = 0; k < 8; k++) begin
            get_bin(re, im, idx, last, w);
            check("t1_re", 64'(re), 64'(tbl[k].exp_re));
            check("t1_im", 64'(im), 64'(tbl[k].exp_im));
            check("t1_idx", 64'(idx), 64'(k));
            check("t1_last", 64'(last), 64'(tbl[k].exp_last));
        end
        tick();
        check("t1_fcnt", 64'(fcnt), 64'd1);
        check("t1_idle", 64'({busy, stream.out_valid}), 64'd0);

        // Backpressure holds bin 0 stable.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            fr_re[0][k] = DW'(16'h0100 + k);
            fr_im[0][k] = DW'(16'hF100 - k);
        end
        push_frame(0, 1'b0);
        for (int i = 0; i < 200 && !stream.out_valid; i++) tick();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!stream.out_valid || stream.out_re != fr_re[0][0] ||
                stream.out_im != fr_im[0][0] || stream.out_index != 3'd0) stable = 1'b0;
            tick();
        end
        check("t2_stable", 64'(stable), 64'd1);
        stream.out_ready = 1'b1;
        recv_frame(0, "t2", waits);
        tick();
        check("t2_fcnt", 64'(fcnt), 64'd1);

        // Second frame parks in HOLD, then both drain with no bubble.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            fr_re[0][k] = DW'(16'h0200 + k);
            fr_im[0][k] = DW'(16'h0A00 + k);
            fr_re[1][k] = DW'(16'h0300 + k);
            fr_im[1][k] = DW'(16'h0B00 + k);
        end
        push_frame(0, 1'b0);
        push_frame(1, 1'b0);
        for (int i = 0; i < LAT + 4; i++) tick();
        check("t3_hold_in_ready", 64'(stream.in_ready), 64'd0);
        check("t3_hold_busy", 64'(busy), 64'd1);
        check("t3_hold_bin0", 64'({stream.out_valid, stream.out_index, stream.out_re}),
              64'({1'b1, 3'd0, fr_re[0][0]}));
        stream.out_ready = 1'b1;
        recv_frame(0, "t3a", waits);
        check("t3a_waits", 64'(waits), 64'd0);
        recv_frame(1, "t3b", waits);
        check("t3b_waits", 64'(waits), 64'd0);
        tick();
        check("t3_fcnt", 64'(fcnt), 64'd2);

        // Gappy input, and in_valid held during COMPUTE with junk data.
        do_reset();
        stream.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fr_re[0][k] = DW'(16'h1234 + 16'h0101 * k);
            fr_im[0][k] = DW'(16'hC000 + 16'h0011 * k);
            fr_re[1][k] = DW'(16'h4000 + k);
            fr_im[1][k] = DW'(16'h5000 + k);
        end
        push_frame(0, 1'b1);
        stream.in_valid = 1'b1;
        stream.in_re    = 16'h5A5A;
        stream.in_im    = 16'hA5A5;
        tick();
        check("t4_compute_in_ready", 64'(stream.in_ready), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        stream.in_valid = 1'b0;
        recv_frame(0, "t4a", waits);
        push_frame(1, 1'b1);
        recv_frame(1, "t4b", waits);

        // Reset mid-fill and mid-drain, then full-scale data.
        do_reset();
        stream.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_sample(16'h1111, 16'h2222, 1'b0);
        rst = 1'b1;
        stream.in_valid = 1'b0;
        tick();
        check_reset_state("t5_fill");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fr_re[0][k] = 16'h7FFF;
            fr_im[0][k] = 16'h8000;
        end
        push_frame(0, 1'b0);
        for (int k = 0; k < 3; k++) get_bin(re, im, idx, last, w);
        check("t5_mid_idx", 64'(stream.out_index), 64'd3);
        rst = 1'b1;
        tick();
        check_reset_state("t5_drain");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fr_re[0][k] = k[0] ? 16'h8000 : 16'h7FFF;
            fr_im[0][k] = k[0] ? 16'h7FFF : 16'h8000;
        end
        push_frame(0, 1'b0);
        recv_frame(0, "t5", waits);
        tick();
        check("t5_fcnt", 64'(fcnt), 64'd1);

        // frame_count wrap (CW-bit counter).
        do_reset();
        stream.out_ready = 1'b1;
        for (int n = 0; n < (1 << CW); n++) begin
            for (int k = 0; k < 8; k++) begin
                fr_re[0][k] = DW'(n * 8 + k);
                fr_im[0][k] = DW'(~(n * 8 + k));
            end
            push_frame(0, 1'b0);
        end
        wait_idle("t6_idle_a");
        check("t6_fcnt_wrap0", 64'(fcnt), 64'd0);
        push_frame(0, 1'b0);
        wait_idle("t6_idle_b");
        check("t6_fcnt_wrap1", 64'(fcnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
